mmmul_arbiter: RTL and testbench



---
 rtl/mmmul_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/mmmul_arbiter.sv | 148 ++++++++++++++
 tb/tb_mmmul_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmmul_arb_pkg.sv
// mmmul_arb_pkg: shared word type, FSM state encoding and constants for the mmmul arbiter.
package mmmul_arb_pkg;

    typedef logic [31:0] float_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } arb_state_t;

    localparam float_word_t FP_ONE = 32'h3F80_0000;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the search starts just above the last owner and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] winner,
    output logic               any
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmmul_arbiter.sv
// mmmul_arbiter: shares one mmmul engine between NUM_REQ requesters in round-robin order.
// Optional hung-engine watchdog is built when MMMUL_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; winner's operands latched on acceptance
// RUN   | engine enabled, waiting for a rising edge on mm_done
// RESP  | one-cycle rsp_valid pulse to the owner
// CLEAR | engine reset for one cycle, owner becomes round-robin pointer
module mmmul_arbiter
    import mmmul_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ROWS1          = 4,
    parameter int COLS1          = 4,
    parameter int ROWS2          = 4,
    parameter int COLS2          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_REQ-1:0]                               req,
    input  float_word_t [NUM_REQ-1:0][ROWS1-1:0][COLS1-1:0]  req_matrix1,
    input  float_word_t [NUM_REQ-1:0][ROWS2-1:0][COLS2-1:0]  req_matrix2,
    output logic [NUM_REQ-1:0]                               gnt,
    output logic [NUM_REQ-1:0]                               rsp_valid,
    output float_word_t [ROWS1-1:0][COLS2-1:0]               rsp_result,
    output logic                                             rsp_error,
    output logic                                             busy,
    output logic                                             mm_rst,
    output logic                                             mm_enable,
    output float_word_t [ROWS1-1:0][COLS1-1:0]               mm_matrix1,
    output float_word_t [ROWS2-1:0][COLS2-1:0]               mm_matrix2,
    input  logic                                             mm_done,
    input  float_word_t [ROWS1-1:0][COLS2-1:0]               mm_result
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || COLS1 != ROWS2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mmmul_arbiter: inconsistent parameters");
    end

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      last_q, owner_q, win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               any_req, done_q, done_rise, timeout, accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req    (req),
        .last   (last_q),
        .winner (win_oh),
        .any    (any_req)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = IW'(i);
        end
    end

    // done_q is forced low in CLEAR so a level left high by the previous job is not mistaken for a rise
    assign done_rise = mm_done & ~done_q;
    assign accept    = (state_q == IDLE) && any_req;

`ifdef MMMUL_ARB_TIMEOUT_EN
    logic [31:0] wdog_q;
    logic        err_q;

    assign timeout   = (state_q == RUN) && (wdog_q == 32'd0);
    assign rsp_error = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            wdog_q <= 32'(TIMEOUT_CYCLES);
            err_q  <= 1'b0;
        end else if (state_q == RUN && !done_rise) begin
            if (timeout) err_q  <= 1'b1;
            else         wdog_q <= wdog_q - 32'd1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        mm_enable = 1'b0;
        mm_rst    = rst;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (any_req) state_d = RUN;
            end
            RUN: begin
                mm_enable = 1'b1;
                if (done_rise || timeout) state_d = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                state_d            = CLEAR;
            end
            CLEAR: begin
                mm_rst  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= IW'(NUM_REQ - 1);
            owner_q    <= '0;
            gnt        <= '0;
            done_q     <= 1'b0;
            rsp_result <= '0;
            mm_matrix1 <= '0;
            mm_matrix2 <= '0;
        end else begin
            gnt    <= '0;
            done_q <= (state_q == CLEAR) ? 1'b0 : mm_done;
            if (accept) begin
                gnt        <= win_oh;
                owner_q    <= win_idx;
                mm_matrix1 <= req_matrix1[win_idx];
                mm_matrix2 <= req_matrix2[win_idx];
            end
            if (state_q == RUN) begin
                if (done_rise)    rsp_result <= mm_result;
                else if (timeout) rsp_result <= '0;
            end
            if (state_q == CLEAR) last_q <= owner_q;
        end
    end

endmodule

// File: tb/tb_mmmul_arbiter.sv
// tb_mmmul_arbiter: self-checking bench for mmmul_arbiter driving a behavioural engine stub.
// Directed vector table, multi-cycle corner sequences and a randomised run against a round-robin model.
module tb_mmmul_arbiter;
    import mmmul_arb_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 16;
    localparam float_word_t FP_TWO = 32'h4000_0000;

    typedef float_word_t [3:0][3:0] mat_t;

    typedef struct {
        logic [1:0]  req;
        int          lat;
        float_word_t a0;
        float_word_t a1;
        float_word_t b;
        logic [1:0]  exp_gnt;
        float_word_t exp_diag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    float_word_t [N-1:0][3:0][3:0] req_matrix1 = '0;
    float_word_t [N-1:0][3:0][3:0] req_matrix2 = '0;
    logic [N-1:0] gnt, rsp_valid;
    mat_t rsp_result, mm_matrix1, mm_matrix2, mm_result;
    logic rsp_error, busy, mm_rst, mm_enable, mm_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Engine stub: raises done after stub_lat enabled cycles, holds it until mm_rst.
    int   stub_lat   = 2;
    int   stub_cnt   = 0;
    logic stub_done  = 1'b0;
    logic stub_hang  = 1'b0;
    logic force_done = 1'b0;
    mat_t stub_res   = '0;

    assign mm_done   = stub_done | force_done;
    assign mm_result = stub_res;

    mmmul_arbiter #(
        .NUM_REQ(N), .ROWS1(4), .COLS1(4), .ROWS2(4), .COLS2(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_matrix1(req_matrix1), .req_matrix2(req_matrix2),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .busy(busy), .mm_rst(mm_rst), .mm_enable(mm_enable),
        .mm_matrix1(mm_matrix1), .mm_matrix2(mm_matrix2),
        .mm_done(mm_done), .mm_result(mm_result)
    );

    always #5 clk = ~clk;

    // Stub arithmetic: exact for 0 and 1.0 operands, an arbitrary bit scramble otherwise.
    function automatic float_word_t fmul(float_word_t x, float_word_t y);
        if (x == '0 || y == '0) return '0;
        if (y == FP_ONE) return x;
        if (x == FP_ONE) return y;
        return x ^ {y[15:0], y[31:16]};
    endfunction

    function automatic float_word_t fadd(float_word_t x, float_word_t y);
        if (x == '0) return y;
        if (y == '0) return x;
        return x + y;
    endfunction

    function automatic mat_t engine_fn(mat_t a, mat_t b);
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                r[i][j] = '0;
                for (int k = 0; k < 4; k++) r[i][j] = fadd(r[i][j], fmul(a[i][k], b[k][j]));
            end
        return r;
    endfunction

    function automatic mat_t diag(float_word_t d);
        mat_t m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = d;
        return m;
    endfunction

    always @(posedge clk) begin
        if (mm_rst) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else if (mm_enable && !stub_done && !stub_hang) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 >= stub_lat) begin
                stub_done <= 1'b1;
                stub_res  <= engine_fn(mm_matrix1, mm_matrix2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit first);
        rst = 1'b1;
        step();
        step();
        check("reset mm_rst while rst", mm_rst, 1);
        rst = 1'b0;
        #1;
        check("reset gnt", gnt, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset busy", busy, 0);
        check("reset mm_enable", mm_enable, 0);
        check("reset mm_rst", mm_rst, 0);
        check("reset rsp_error", rsp_error, 0);
        if (first) check("reset rsp_result", rsp_result, 0);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == '0 && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int n;
        req_matrix1[0] = diag(v.a0);
        req_matrix2[0] = diag(v.b);
        req_matrix1[1] = diag(v.a1);
        req_matrix2[1] = diag(v.b);
        stub_lat = v.lat;
        req = v.req;
        step();
        check({tag, " gnt"}, gnt, v.exp_gnt);
        check({tag, " busy"}, busy, 1);
        check({tag, " mm_enable"}, mm_enable, 1);
        req = '0;
        wait_rsp(n);
        check({tag, " latency"}, n, v.lat + 1);
        check({tag, " rsp_valid"}, rsp_valid, v.exp_gnt);
        check({tag, " rsp_result"}, rsp_result, diag(v.exp_diag));
        check({tag, " rsp_error"}, rsp_error, 0);
        step();
        check({tag, " clear mm_rst"}, mm_rst, 1);
        check({tag, " clear mm_enable"}, mm_enable, 0);
        check({tag, " clear rsp_valid"}, rsp_valid, 0);
        step();
        check({tag, " idle busy"}, busy, 0);
        check({tag, " result held"}, rsp_result, diag(v.exp_diag));
    endtask

    vec_t vecs[9];

    initial begin
        int n, cyc, last_g, idle_from, rsp_at, m_last, m_owner, lat, w, idx;
        logic seen;
        logic [1:0] drv_req, exp_g, exp_r, exp_tab;
        mat_t drv_m1[2];
        mat_t drv_m2[2];
        mat_t m_exp;

        vecs[0] = '{2'b01, 2, FP_ONE,        FP_TWO,        FP_ONE,        2'b01, FP_ONE};
        vecs[1] = '{2'b11, 3, FP_ONE,        FP_TWO,        FP_ONE,        2'b10, FP_TWO};
        vecs[2] = '{2'b11, 1, 32'h3FC0_0000, 32'h4040_0000, FP_ONE,        2'b01, 32'h3FC0_0000};
        vecs[3] = '{2'b11, 4, 32'h3FC0_0000, 32'h4040_0000, FP_ONE,        2'b10, 32'h4040_0000};
        vecs[4] = '{2'b10, 2, FP_TWO,        FP_ONE,        32'hC000_0000, 2'b10, 32'hC000_0000};
        vecs[5] = '{2'b10, 1, FP_ONE,        32'h4080_0000, FP_ONE,        2'b10, 32'h4080_0000};
        vecs[6] = '{2'b01, 5, 32'hBF80_0000, FP_TWO,        FP_ONE,        2'b01, 32'hBF80_0000};
        vecs[7] = '{2'b01, 2, FP_ONE,        FP_TWO,        FP_ONE,        2'b01, FP_ONE};
        vecs[8] = '{2'b11, 3, FP_TWO,        32'h4100_0000, FP_ONE,        2'b10, 32'h4100_0000};

        do_reset(1'b1);

        for (int i = 0; i < 9; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Withdrawal: requester 1 pulses req while job 0 runs and must never be granted.
        req_matrix1[0] = diag(FP_ONE);
        req_matrix2[0] = diag(FP_ONE);
        stub_lat = 6;
        req = 2'b01;
        step();
        check("withdraw gnt0", gnt, 2'b01);
        req = 2'b10;
        step();
        req = '0;
        seen = 1'b0;
        n = 0;
        while (rsp_valid == '0 && n < 60) begin
            seen |= gnt[1];
            step();
            n++;
        end
        check("withdraw rsp_valid", rsp_valid, 2'b01);
        step();
        step();
        check("withdraw busy falls", busy, 0);
        for (int i = 0; i < 10; i++) begin
            seen |= gnt[1];
            step();
        end
        check("withdraw no gnt1", seen, 0);

        // Done already high on entry to RUN must wait for a fresh rising edge.
        force_done = 1'b1;
        stub_lat = 6;
        req = 2'b01;
        step();
        check("stale done gnt", gnt, 2'b01);
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen |= |rsp_valid;
        end
        check("stale done ignored", seen, 0);
        force_done = 1'b0;
        wait_rsp(n);
        check("stale done latency", n + 3, 7);
        check("stale done rsp_valid", rsp_valid, 2'b01);
        step();
        step();

        // Reset two cycles after gnt abandons the job.
        stub_lat = 8;
        req = 2'b01;
        step();
        check("midrst gnt", gnt, 2'b01);
        req = '0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst mm_rst", mm_rst, 1);
        step();
        rst = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen |= |rsp_valid;
            step();
        end
        check("midrst no rsp_valid", seen, 0);

        // Fairness from reset: both hold req for four jobs, grants alternate 0,1,0,1.
        req_matrix1[0] = diag(FP_ONE);
        req_matrix2[0] = diag(FP_ONE);
        req_matrix1[1] = diag(FP_TWO);
        req_matrix2[1] = diag(FP_ONE);
        stub_lat = 3;
        req = 2'b11;
        cyc = 0;
        last_g = 0;
        for (int j = 0; j < 4; j++) begin
            exp_tab = (j % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (gnt == '0 && n < 40) begin
                step();
                n++;
                cyc++;
            end
            check($sformatf("fair gnt%0d", j), gnt, exp_tab);
            if (j > 0) check($sformatf("fair spacing%0d", j), cyc - last_g, 7);
            last_g = cyc;
            if (j == 3) req = '0;
            n = 0;
            while (rsp_valid == '0 && n < 40) begin
                step();
                n++;
                cyc++;
            end
            check($sformatf("fair rsp_valid%0d", j), rsp_valid, exp_tab);
            check($sformatf("fair result%0d", j), rsp_result, diag((j % 2 == 0) ? FP_ONE : FP_TWO));
        end
        step();
        step();

`ifdef MMMUL_ARB_TIMEOUT_EN
        stub_hang = 1'b1;
        req_matrix1[0] = diag(FP_TWO);
        req_matrix2[0] = diag(FP_ONE);
        req = 2'b01;
        step();
        check("timeout gnt", gnt, 2'b01);
        req = '0;
        wait_rsp(n);
        check("timeout latency", n, TMO + 1);
        check("timeout rsp_valid", rsp_valid, 2'b01);
        check("timeout rsp_error", rsp_error, 1);
        check("timeout rsp_result", rsp_result, 0);
        step();
        check("timeout clear mm_rst", mm_rst, 1);
        step();
        check("timeout busy", busy, 0);
        stub_hang = 1'b0;
`endif

        // Randomised run against a round-robin reference model.
        do_reset(1'b0);
        m_last = N - 1;
        m_owner = 0;
        idle_from = 0;
        rsp_at = -10;
        cyc = 0;
        drv_req = '0;
        m_exp = '0;
        for (int i = 0; i < N; i++) begin
            drv_m1[i] = '0;
            drv_m2[i] = '0;
        end
        for (int it = 0; it < 1500; it++) begin
            step();
            cyc++;
            exp_g = '0;
            exp_r = '0;
            if (cyc - 1 >= idle_from && drv_req != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (w < 0 && drv_req[idx]) w = idx;
                end
                exp_g[w] = 1'b1;
                m_owner = w;
                m_last = w;
                m_exp = engine_fn(drv_m1[w], drv_m2[w]);
                lat = $urandom_range(1, 5);
                stub_lat = lat;
                rsp_at = cyc + lat + 1;
                idle_from = cyc + lat + 3;
            end
            if (cyc == rsp_at) exp_r[m_owner] = 1'b1;
            check("rand gnt", gnt, exp_g);
            check("rand rsp_valid", rsp_valid, exp_r);
            check("rand busy", busy, cyc < idle_from);
            check("rand mm_rst", mm_rst, cyc == rsp_at + 1);
            if (exp_r != '0) begin
                check("rand rsp_result", rsp_result, m_exp);
                check("rand rsp_error", rsp_error, 0);
            end
            for (int i = 0; i < N; i++) begin
                if (drv_req[i] && !exp_g[i]) begin
                    if ($urandom_range(0, 9) == 0) drv_req[i] = 1'b0;
                end else if (!drv_req[i] && ($urandom_range(0, 3) != 0)) begin
                    // idle requester stays idle this cycle
                end else if (drv_req[i] && exp_g[i] && $urandom_range(0, 1) == 0) begin
                    drv_req[i] = 1'b0;
                end else begin
                    drv_req[i] = 1'b1;
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) begin
                            case ($urandom_range(0, 3))
                                0: drv_m1[i][r][c] = '0;
                                1: drv_m1[i][r][c] = FP_ONE;
                                default: drv_m1[i][r][c] = float_word_t'($urandom);
                            endcase
                            case ($urandom_range(0, 3))
                                0: drv_m2[i][r][c] = '0;
                                1: drv_m2[i][r][c] = FP_ONE;
                                default: drv_m2[i][r][c] = float_word_t'($urandom);
                            endcase
                        end
                end
                req_matrix1[i] = drv_m1[i];
                req_matrix2[i] = drv_m2[i];
            end
            req = drv_req;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
